// File: rtl/alu_operand_stage.sv
// ALU operand A/B resolution with register-file bypass, registered into a single ID/EX slot.
// Define ALU_OPERAND_FWD_STATS_EN to add the fwd_hits forwarded-instruction counter output.
module alu_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      alu_src_a,
    input  logic                      alu_src_b,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [REG_AW-1:0]         rs2_addr,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [XLEN-1:0]           pc,
    input  logic [XLEN-1:0]           imm,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           op_a,
    output logic [XLEN-1:0]           op_b,
`ifdef ALU_OPERAND_FWD_STATS_EN
    output logic [31:0]               fwd_hits,
`endif
    output logic [XLEN-1:0]           store_data
);

    // Walk from oldest to youngest so the lowest matching index wins; x0 always reads zero.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_AW-1:0]         addr,
        input logic [XLEN-1:0]           rf_data,
        input logic [NUM_FWD-1:0]        f_valid,
        input logic [NUM_FWD*REG_AW-1:0] f_rd,
        input logic [NUM_FWD*XLEN-1:0]   f_data
    );
        logic [XLEN-1:0] r;
        r = rf_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (f_valid[i] && (f_rd[i*REG_AW +: REG_AW] == addr))
                r = f_data[i*XLEN +: XLEN];
        end
        if (addr == '0)
            r = '0;
        return r;
    endfunction

`ifdef ALU_OPERAND_FWD_STATS_EN
    function automatic logic fwd_hit(
        input logic [REG_AW-1:0]         addr,
        input logic [NUM_FWD-1:0]        f_valid,
        input logic [NUM_FWD*REG_AW-1:0] f_rd
    );
        logic h;
        h = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (f_valid[i] && (f_rd[i*REG_AW +: REG_AW] == addr))
                h = 1'b1;
        end
        return h && (addr != '0);
    endfunction
`endif

    logic            accept;
    logic [XLEN-1:0] res_rs1;
    logic [XLEN-1:0] res_rs2;
    logic            vld_p0;
    logic [XLEN-1:0] op_a_p0;
    logic [XLEN-1:0] op_b_p0;
    logic [XLEN-1:0] store_p0;

    assign res_rs1  = resolve(rs1_addr, rs1_data, fwd_valid, fwd_rd, fwd_data);
    assign res_rs2  = resolve(rs2_addr, rs2_data, fwd_valid, fwd_rd, fwd_data);
    assign in_ready = !flush && (!vld_p0 || out_ready);
    assign accept   = in_valid && in_ready;

    // ---- ID/EX register (p0) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            op_a_p0  <= '0;
            op_b_p0  <= '0;
            store_p0 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0   <= 1'b1;
            op_a_p0  <= alu_src_a ? pc  : res_rs1;
            op_b_p0  <= alu_src_b ? imm : res_rs2;
            store_p0 <= res_rs2;
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid  = vld_p0;
    assign op_a       = op_a_p0;
    assign op_b       = op_b_p0;
    assign store_data = store_p0;

`ifdef ALU_OPERAND_FWD_STATS_EN
    logic        hit_any;
    logic [31:0] hits_p0;

    assign hit_any = (!alu_src_a && fwd_hit(rs1_addr, fwd_valid, fwd_rd)) ||
                     (!alu_src_b && fwd_hit(rs2_addr, fwd_valid, fwd_rd));

    // accept is already false while flushing, so flushed cycles never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hits_p0 <= '0;
        else if (accept && hit_any)
            hits_p0 <= hits_p0 + 32'd1;
    end

    assign fwd_hits = hits_p0;
`endif

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised successor to the combinational ALU operand-B select. It resolves both ALU operands (A: rs1/PC, B: rs2/immediate) with register-file bypass from NUM_FWD later pipeline stages. It also produces forwarded store data. All outputs are registered into a single-entry ID/EX pipeline register with valid/ready handshake and flush. It sits between decode/register-read and the ALU.

Parameters:
XLEN, 32, datapath width of operands, immediate, PC and forward data
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (highest priority)
REG_AW, 5, register address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents a valid instruction
in_ready  output  1  stage can accept this cycle
alu_src_a  input  1  1: op_a = pc, 0: op_a = resolved rs1
alu_src_b  input  1  1: op_b = imm, 0: op_b = resolved rs2
rs1_addr  input  REG_AW  source register 1 index
rs2_addr  input  REG_AW  source register 2 index
rs1_data  input  XLEN  register-file read data 1
rs2_data  input  XLEN  register-file read data 2
pc  input  XLEN  instruction address
imm  input  XLEN  sign-extended immediate
fwd_valid  input  NUM_FWD  per-source write-enable of producing stage
fwd_rd  input  NUM_FWD*REG_AW  per-source destination index, source i at bits [i*REG_AW +: REG_AW]
fwd_data  input  NUM_FWD*XLEN  per-source result, source i at bits [i*XLEN +: XLEN]
flush  input  1  kill held and incoming instruction
out_valid  output  1  registered operands valid
out_ready  input  1  ALU/EX stage accepts
op_a  output  XLEN  registered operand A
op_b  output  XLEN  registered operand B
store_data  output  XLEN  registered resolved rs2 (independent of alu_src_b)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0; op_a, op_b and store_data = 0. Reset mid-transfer discards the held entry.
- in_ready = !flush && (!out_valid || out_ready). Combinational, no dependency on in_valid.
- Capture: on the clock edge with in_valid && in_ready, the register loads the resolved operands and out_valid<=1. Latency: 1 cycle from accept to out_valid.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid<=0. Data registers keep their last value.
- Stall: out_valid && !out_ready -> op_a, op_b and store_data are held bit-stable, and in_ready=0.
- Simultaneous drain and capture: back-to-back throughput of 1 per cycle, no bubble.
- Flush: takes priority over everything. Next edge gives out_valid<=0 and no capture, even if in_valid. Data registers are unchanged.
- Operand resolution (combinational before the register), for each rs in {rs1, rs2}:
  - If rs_addr==0, the result is 0 regardless of rs_data or forwards.
  - Otherwise, the lowest index i with fwd_valid[i] && fwd_rd[i]==rs_addr supplies fwd_data[i].
  - Otherwise the result is rs_data.
- fwd_rd==0 never matches. Multiple matches resolve by priority only.
- op_a = alu_src_a ? pc : res_rs1.
- op_b = alu_src_b ? imm : res_rs2.
- store_data = res_rs2.
- There is no arithmetic. All widths are XLEN with no truncation or extension inside the block.

Optional Feature:
Macro ALU_OPERAND_FWD_STATS_EN.
- When defined, the block adds output port fwd_hits (32 bits, reset 0).
- fwd_hits increments by 1 on each accepted instruction where at least one consumed operand was forwarded. A consumed operand is rs1 with alu_src_a=0, or rs2 with alu_src_b=0.
- fwd_hits wraps from 0xFFFFFFFF to 0. It does not increment on flushed or unaccepted cycles.
- When not defined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-stall with out_valid=1 -> out_valid=0 and op_a/op_b/store_data=0 immediately, without waiting for a clock edge.
- Immediate select: rs2_data=0x11111111, imm=0xFFFFF800, alu_src_b=1, in_valid=1 -> one cycle later out_valid=1, op_b=0xFFFFF800, store_data=0x11111111.
- Forward priority: rs1_addr=5; fwd0 = (valid, rd=5, 0xAAAA0000); fwd1 = (valid, rd=5, 0xBBBB0000); rs1_data=0xCCCC0000 -> op_a=0xAAAA0000. Deassert fwd0 valid -> op_a=0xBBBB0000.
- x0 guard: rs2_addr=0, rs2_data=0xDEADBEEF, fwd0 = (valid, rd=0, 0x12345678), alu_src_b=0 -> op_b=0 and store_data=0.
- Backpressure and throughput: hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Then stream 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles in order, no bubbles.
- Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0 and the input is not captured. With ALU_OPERAND_FWD_STATS_EN defined, fwd_hits is unchanged.
